// File: rtl/ec_harness_pkg.sv
// ec_harness_pkg: shared state encoding and status-bit helper for the serial EC harness
package ec_harness_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    // The status bit sits just above the result in the outgoing frame, so it leaves first
    function automatic int status_pos(input int out_width);
        return out_width;
    endfunction

endpackage

// File: rtl/ec_harness_shreg.sv
// ec_harness_shreg: left-shifting register with parallel load and serial LSB input
module ec_harness_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    // Parallel load has priority over shifting; bits move toward the MSB
    always_comb q_d = load ? load_val : shift ? (q_q << 1) | WIDTH'(sin) : q_q;

    // Register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ec_serial_harness_ctrl.sv
// ec_serial_harness_ctrl: framed serial load / launch / wait / unload controller for EC cores
module ec_serial_harness_ctrl
    import ec_harness_pkg::*;
#(
    parameter int IN_WIDTH  = 236,
    parameter int OUT_WIDTH = 467,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_in_valid,
    output logic                 bit_out,
    output logic                 bit_out_valid,
    output logic [IN_WIDTH-1:0]  dut_word,
    output logic                 dut_start,
    output logic                 dut_clr,
    input  logic                 dut_done,
    input  logic [OUT_WIDTH-1:0] dut_result,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun_err
);

    localparam int ICW = $clog2(IN_WIDTH + 1);
    localparam int OCW = $clog2(OUT_WIDTH + 2);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam int OW1 = OUT_WIDTH + 1;
    localparam int SP  = status_pos(OUT_WIDTH);

    state_t              state_q, state_d;
    logic [ICW-1:0]      in_cnt_q, in_cnt_d;
    logic [OCW-1:0]      out_cnt_q, out_cnt_d;
    logic [TCW-1:0]      tmr_q, tmr_d;
    logic [IN_WIDTH-1:0] dut_word_q, dut_word_d;
    logic                dut_start_q, dut_start_d;
    logic                dut_clr_q, dut_clr_d;
    logic                busy_q, busy_d;
    logic                bit_out_valid_q, bit_out_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic                overrun_err_q, overrun_err_d;

    logic                in_shift;
    logic [IN_WIDTH-1:0] in_sr;
    logic                out_load, out_shift;
    logic [OW1-1:0]      out_val, out_sr;

    ec_harness_shreg #(.WIDTH(IN_WIDTH)) u_in_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ({IN_WIDTH{1'b0}}),
        .shift    (in_shift),
        .sin      (bit_in),
        .q        (in_sr)
    );

    ec_harness_shreg #(.WIDTH(OW1)) u_out_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (out_load),
        .load_val (out_val),
        .shift    (out_shift),
        .sin      (1'b0),
        .q        (out_sr)
    );

    // Next-state, counters, shift controls and next values of the registered outputs
    always_comb begin
        state_d       = state_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        tmr_d         = tmr_q;
        dut_word_d    = dut_word_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q | (bit_in_valid && state_q != S_LOAD);
        in_shift      = 1'b0;
        out_load      = 1'b0;
        out_shift     = 1'b0;
        out_val       = {1'b0, dut_result};
        case (state_q)
            S_LOAD: begin
                if (bit_in_valid) begin
                    in_shift = 1'b1;
                    if (in_cnt_q == ICW'(IN_WIDTH - 1)) begin
                        in_cnt_d   = '0;
                        dut_word_d = (in_sr << 1) | IN_WIDTH'(bit_in);
                        state_d    = S_LAUNCH;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (dut_done) begin
                    out_load = 1'b1;
                    state_d  = S_UNLOAD;
                end else if (tmr_q == TCW'(TIMEOUT - 1)) begin
                    out_load      = 1'b1;
                    out_val       = '0;
                    out_val[SP]   = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                out_shift = 1'b1;
                if (out_cnt_q == OCW'(OUT_WIDTH)) begin
                    out_cnt_d = '0;
                    state_d   = S_LOAD;
                end else begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
        // Pulses are decoded one cycle early so they come straight out of flops
        dut_start_d     = state_d == S_LAUNCH;
        dut_clr_d       = state_d == S_WAIT && tmr_d == TCW'(TIMEOUT - 1);
        busy_d          = state_d != S_LOAD;
        bit_out_valid_d = state_d == S_UNLOAD;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_LOAD;
            in_cnt_q        <= '0;
            out_cnt_q       <= '0;
            tmr_q           <= '0;
            dut_word_q      <= '0;
            dut_start_q     <= 1'b0;
            dut_clr_q       <= 1'b0;
            busy_q          <= 1'b0;
            bit_out_valid_q <= 1'b0;
            timeout_err_q   <= 1'b0;
            overrun_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_cnt_q        <= in_cnt_d;
            out_cnt_q       <= out_cnt_d;
            tmr_q           <= tmr_d;
            dut_word_q      <= dut_word_d;
            dut_start_q     <= dut_start_d;
            dut_clr_q       <= dut_clr_d;
            busy_q          <= busy_d;
            bit_out_valid_q <= bit_out_valid_d;
            timeout_err_q   <= timeout_err_d;
            overrun_err_q   <= overrun_err_d;
        end
    end

    assign bit_out       = out_sr[SP];
    assign bit_out_valid = bit_out_valid_q;
    assign dut_word      = dut_word_q;
    assign dut_start     = dut_start_q;
    assign dut_clr       = dut_clr_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_ec_serial_harness_ctrl.sv
// tb_ec_serial_harness_ctrl: randomized self-checking bench with a transaction-level reference model
module tb_ec_serial_harness_ctrl;

    localparam int IW = 8;
    localparam int OW = 12;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_in_valid = 1'b0;
    logic          dut_done = 1'b0;
    logic [OW-1:0] dut_result = '0;
    logic          bit_out, bit_out_valid, dut_start, dut_clr, busy, timeout_err, overrun_err;
    logic [IW-1:0] dut_word;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic exp_terr = 1'b0;
    logic exp_oerr = 1'b0;

    ec_serial_harness_ctrl #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .bit_in_valid  (bit_in_valid),
        .bit_out       (bit_out),
        .bit_out_valid (bit_out_valid),
        .dut_word      (dut_word),
        .dut_start     (dut_start),
        .dut_clr       (dut_clr),
        .dut_done      (dut_done),
        .dut_result    (dut_result),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Streams an operand MSB first, one valid bit every gap cycles, then checks the launch
    task automatic send_operand(input logic [IW-1:0] v, input int gap);
        int bad = 0;
        for (int i = IW - 1; i >= 0; i--) begin
            for (int g = 1; g < gap; g++) begin
                bit_in_valid = 1'b0;
                @(negedge clk);
                if (dut_start) bad++;
            end
            bit_in_valid = 1'b1;
            bit_in = v[i];
            @(negedge clk);
            if (i > 0 && dut_start) bad++;
        end
        bit_in_valid = 1'b0;
        bit_in = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL start_early: got %0d early starts, want 0", bad);
        else passed++;
        total++;
        if (dut_start !== 1'b1) $display("FAIL start_pulse: got %b want 1", dut_start);
        else passed++;
        start_cyc = cyc;
        total++;
        if (dut_word !== v) $display("FAIL dut_word: got %h want %h", dut_word, v);
        else passed++;
        total++;
        if (busy !== 1'b1) $display("FAIL busy_launch: got %b want 1", busy);
        else passed++;
    endtask

    // Plays the core: done arrives in WAIT cycle k (k>=TO means never), then checks the frame
    task automatic run_core(input int k, input logic [OW-1:0] res, input bit hold, input bit inject);
        logic [OW:0] exp_f, got;
        bit tmo;
        int bad = 0;
        int bad2 = 0;
        tmo = (k >= TO);
        exp_f = tmo ? {1'b1, {OW{1'b0}}} : {1'b0, res};
        if (tmo) exp_terr = 1'b1;
        if (inject) exp_oerr = 1'b1;
        dut_result = res;
        if (hold) dut_done = 1'b1;
        @(negedge clk);
        for (int j = 0; j < TO; j++) begin
            if (dut_start || !busy || bit_out_valid) bad++;
            if (!(k == TO - 1 && j == TO - 1) && dut_clr !== (tmo && j == TO - 1)) bad++;
            if (j == k) dut_done = 1'b1;
            @(negedge clk);
            if (!hold) dut_done = 1'b0;
            if (j >= k) break;
        end
        total++;
        if (bad !== 0) $display("FAIL wait_phase: got %0d bad cycles, want 0 (k=%0d)", bad, k);
        else passed++;
        for (int i = OW; i >= 0; i--) begin
            if (bit_out_valid !== 1'b1) bad2++;
            got[i] = bit_out;
            last_valid_cyc = cyc;
            if (inject && i == OW - 2) begin
                bit_in_valid = 1'b1;
                bit_in = 1'($urandom);
            end
            @(negedge clk);
            bit_in_valid = 1'b0;
        end
        dut_done = 1'b0;
        total++;
        if (bad2 !== 0) $display("FAIL frame_valid: got %0d gaps, want 0", bad2);
        else passed++;
        total++;
        if (got !== exp_f) $display("FAIL frame_bits: got %h want %h", got, exp_f);
        else passed++;
        total++;
        if (bit_out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL frame_end: got valid=%b busy=%b want 0 0", bit_out_valid, busy);
        else passed++;
        total++;
        if (timeout_err !== exp_terr) $display("FAIL timeout_err: got %b want %b", timeout_err, exp_terr);
        else passed++;
        total++;
        if (overrun_err !== exp_oerr) $display("FAIL overrun_err: got %b want %b", overrun_err, exp_oerr);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bit_out, bit_out_valid, dut_word, dut_start, dut_clr, busy, timeout_err, overrun_err} !== '0)
            $display("FAIL reset_state: got %b want 0", {bit_out, bit_out_valid, dut_word, dut_start, dut_clr, busy, timeout_err, overrun_err});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_operand(8'hA5, 1);
        run_core(4, 12'h3C7, 0, 0);
    endtask

    task automatic test_gapped();
        send_operand(8'h01, 3);
        run_core(2, OW'($urandom), 0, 0);
    endtask

    task automatic test_timeout();
        send_operand(IW'($urandom), 1);
        run_core(TO + 5, OW'($urandom), 0, 0);
        send_operand(IW'($urandom), 2);
        run_core(1, OW'($urandom), 0, 0);
    endtask

    task automatic test_boundary();
        send_operand(IW'($urandom), 1);
        run_core(TO - 1, OW'($urandom), 0, 0);
    endtask

    task automatic test_hold_overrun();
        int bad = 0;
        send_operand(8'h5A, 1);
        run_core(0, 12'hABC, 1, 1);
        repeat (3) begin
            @(negedge clk);
            if (dut_start || bit_out_valid || busy) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL hold_no_retrigger: got %0d bad cycles, want 0", bad);
        else passed++;
        send_operand(8'hC3, 1);
        run_core(3, OW'($urandom), 0, 0);
    endtask

    task automatic test_reset_midframe();
        logic [IW-1:0] junk;
        junk = IW'($urandom);
        for (int i = 0; i < 5; i++) begin
            bit_in_valid = 1'b1;
            bit_in = junk[i];
            @(negedge clk);
        end
        bit_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({bit_out, bit_out_valid, dut_word, dut_start, dut_clr, busy, timeout_err, overrun_err} !== '0)
            $display("FAIL reset_midframe: got %b want 0", {bit_out, bit_out_valid, dut_word, dut_start, dut_clr, busy, timeout_err, overrun_err});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_terr = 1'b0;
        exp_oerr = 1'b0;
        send_operand(8'h3C, 1);
        run_core(3, OW'($urandom), 0, 0);
    endtask

    task automatic test_back_to_back();
        send_operand(IW'($urandom), 1);
        run_core(5, OW'($urandom), 0, 0);
        send_operand(8'h96, 1);
        total++;
        if (start_cyc - last_valid_cyc !== IW + 1) $display("FAIL b2b_latency: got %0d want %0d", start_cyc - last_valid_cyc, IW + 1);
        else passed++;
        run_core(0, OW'($urandom), 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            send_operand(IW'($urandom), int'($urandom_range(1, 3)));
            run_core(int'($urandom_range(0, TO + 3)), OW'($urandom), 0, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_timeout();
        test_boundary();
        test_hold_overrun();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
